branch_redirect_ctrl: RTL
=========================

// Module: branch_redirect_ctrl
// PURPOSE
//  Sequences the PC redirect produced by the EX-stage jump/branch decision in the RV32I pipeline.
//  Static predict-not-taken: a taken jump/branch registers its target and offers it to fetch over a valid/ready handshake.
//  It then flushes the younger IF/ID instructions for FLUSH_DEPTH cycles and returns to idle.
//  Sits between the jump/branch decision logic and the fetch/PC unit; also owns misaligned-target detection.
// PARAMETERS
//  FLUSH_DEPTH  2   cycles o_Flush_1 stays high after redirect acceptance (1..7)
//  CNT_W        16  width of statistics counters (only with BRANCH_STATS_EN)
// PORTS
//  i_Clk_1            in   1   clock, rising edge
//  i_Rst_1            in   1   synchronous active-high reset
//  i_ExValid_1        in   1   EX holds a valid jump/branch instruction this cycle
//  i_JumpBranch_1     in   1   jump/branch taken decision for that instruction
//  i_TargetPC_32      in   32  computed target address
//  i_RedirectReady_1  in   1   fetch accepts the redirect this cycle
//  o_RedirectValid_1  out  1   redirect target offered to fetch
//  o_RedirectPC_32    out  32  registered target; also the faulting target on misalign
//  o_Flush_1          out  1   kill IF/ID instructions (turn them into bubbles)
//  o_Stall_1          out  1   hold EX and earlier stages while a redirect is unaccepted
//  o_MisalignErr_1    out  1   1-cycle pulse: taken target with [1:0]!=0
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0, o_RedirectPC_32=32'h0, flush counter 0. Reset mid-operation drops any pending redirect.
//  - Event "take" = i_ExValid_1 & i_JumpBranch_1 sampled in IDLE. Non-taken or invalid events produce no action.
//  - FSM states IDLE, REDIRECT, FLUSH:
//    IDLE:     take & TargetPC[1:0]==0 -> REDIRECT; latch target into o_RedirectPC_32.
//              take & TargetPC[1:0]!=0 -> stay IDLE; o_MisalignErr_1=1 for the next cycle only; latch target.
//    REDIRECT: o_RedirectValid_1=1, o_Flush_1=1, o_Stall_1=1.
//              On i_RedirectReady_1=1 -> FLUSH with cnt=FLUSH_DEPTH-1, or -> IDLE if FLUSH_DEPTH==1.
//              Otherwise stay; target and valid are held stable (valid never drops before ready).
//    FLUSH:    o_Flush_1=1, o_Stall_1=0, o_RedirectValid_1=0; cnt decrements; cnt==0 -> IDLE.
//  - Latency: take at edge N -> o_RedirectValid_1 and o_Flush_1 high after edge N (registered, 1 cycle).
//  - Total flush cycles per redirect = cycles in REDIRECT + FLUSH_DEPTH-1.
//  - i_ExValid_1 outside IDLE is ignored: that instruction is a wrong-path younger instruction being flushed.
//  - Ready asserted in the same cycle valid first rises: accepted that cycle (minimum 1 REDIRECT cycle).
//  - i_RedirectReady_1 outside REDIRECT: ignored.
//  - All outputs are driven from registers or state decode only; no combinational input-to-output path.
// CONFIGURATION
//  BRANCH_STATS_EN defined: adds ports o_TakenCnt (CNT_W, out) and o_MisalignCnt (CNT_W, out).
//    o_TakenCnt increments on each accepted redirect; o_MisalignCnt increments on each misalign pulse.
//    Both counters saturate at all-ones (no wrap) and clear on i_Rst_1.
//  BRANCH_STATS_EN undefined: these ports and their counters do not exist; core behaviour is identical.
// TESTING
//  1. Reset held 2 cycles -> all outputs 0 and state IDLE; release with no take -> outputs stay 0 for 10 cycles.
//  2. Take, target 32'h0000_0100, ready tied 1, FLUSH_DEPTH=2 -> valid 1 cycle, PC=0x100, flush 2 cycles, stall 1 cycle.
//  3. Take, target 32'h0000_0200, ready low 3 cycles then high -> valid/stall/flush held 4 cycles, PC stable, then flush 1 more cycle.
//  4. Take, target 32'h0000_0102 -> o_MisalignErr_1 high exactly 1 cycle, PC=0x102, no valid/flush/stall.
//  5. Second take asserted while in REDIRECT and FLUSH -> ignored; exactly one redirect is issued.
//  6. i_Rst_1 high in REDIRECT -> next cycle valid/flush/stall 0; with BRANCH_STATS_EN, 2^CNT_W+3 redirects -> o_TakenCnt saturates at all-ones.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// PC redirect sequencer for EX-stage jump/branch decisions (predict-not-taken): offers the
// registered target to fetch, flushes IF/ID, and flags misaligned targets. Optional stats: BRANCH_STATS_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | waiting for a taken jump/branch from EX
// REDIRECT | target offered to fetch; IF/ID flushed and EX stalled until ready
// FLUSH    | redirect accepted; IF/ID still flushed while flushCnt counts down
module branch_redirect_ctrl #(
  parameter int FLUSH_DEPTH = 2
`ifdef BRANCH_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic        i_Clk_1,
  input  logic        i_Rst_1,
  input  logic        i_ExValid_1,
  input  logic        i_JumpBranch_1,
  input  logic [31:0] i_TargetPC_32,
  input  logic        i_RedirectReady_1,
  output logic        o_RedirectValid_1,
  output logic [31:0] o_RedirectPC_32,
  output logic        o_Flush_1,
  output logic        o_Stall_1,
  output logic        o_MisalignErr_1
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] o_TakenCnt,
  output logic [CNT_W-1:0] o_MisalignCnt
`endif
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REDIRECT = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);

  logic [1:0]  state;
  logic [2:0]  flushCnt;
  logic [31:0] redirectPc;
  logic        misalignErr;
  logic        take;
  logic        misaligned;
  logic        accept;
  logic        misalignEvent;

  assign take          = i_ExValid_1 & i_JumpBranch_1;
  assign misaligned    = (i_TargetPC_32[1:0] != 2'b00);
  assign accept        = (state == REDIRECT) & i_RedirectReady_1;
  assign misalignEvent = (state == IDLE) & take & misaligned;

  always_ff @(posedge i_Clk_1) begin
    if (i_Rst_1) begin
      state       <= IDLE;
      flushCnt    <= 3'd0;
      redirectPc  <= 32'h0;
      misalignErr <= 1'b0;
    end else begin
      misalignErr <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            redirectPc <= i_TargetPC_32;
            if (misaligned) misalignErr <= 1'b1;
            else            state       <= REDIRECT;
          end
        end
        REDIRECT: begin
          if (i_RedirectReady_1) begin
            if (FLUSH_DEPTH == 1) begin
              state <= IDLE;
            end else begin
              state    <= FLUSH;
              flushCnt <= FLUSH_LOAD;
            end
          end
        end
        FLUSH: begin
          // The cycle whose count reaches zero is the last flush cycle.
          flushCnt <= flushCnt - 3'd1;
          if (flushCnt == 3'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_RedirectValid_1 = (state == REDIRECT);
  assign o_Stall_1         = (state == REDIRECT);
  assign o_Flush_1         = (state == REDIRECT) | (state == FLUSH);
  assign o_RedirectPC_32   = redirectPc;
  assign o_MisalignErr_1   = misalignErr;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] takenCnt;
  logic [CNT_W-1:0] misalignCnt;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge i_Clk_1) begin
    if (i_Rst_1) begin
      takenCnt    <= '0;
      misalignCnt <= '0;
    end else begin
      if (accept && (takenCnt != {CNT_W{1'b1}}))
        takenCnt <= takenCnt + 1'b1;
      if (misalignEvent && (misalignCnt != {CNT_W{1'b1}}))
        misalignCnt <= misalignCnt + 1'b1;
    end
  end

  assign o_TakenCnt    = takenCnt;
  assign o_MisalignCnt = misalignCnt;
`else
  logic unusedStats;
  assign unusedStats = accept ^ misalignEvent;
`endif

endmodule
